branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have the port `instr`, input, 32 bits: the fetched instruction word.
REQ-004 SHALL have the port `pc`, input, 64 bits: the fetch address of `instr`.
REQ-005 SHALL have the port `valid`, input, 1 bit: `instr` and `pc` are meaningful this cycle.
REQ-006 SHALL have the port `flags`, input, 4 bits: {N,Z,V,C} from the ALU.
REQ-007 SHALL have the port `flags_rdy`, input, 1 bit: `flags` reflect all older instructions.
REQ-008 SHALL have the port `rt_val`, input, 64 bits: the register operand for CBZ.
REQ-009 SHALL have the port `rt_rdy`, input, 1 bit: `rt_val` is current.
REQ-010 SHALL have the port `stall_req`, input, 1 bit: an external hazard freezes the PC.
REQ-011 SHALL have the port `target`, output, 64 bits: the redirect address, driven to the PC next-address input.
REQ-012 SHALL have the port `pc_src`, output, 1 bit: selects `target` over PC+4.
REQ-013 SHALL have the port `pc_en`, output, 1 bit: PC update enable.
REQ-014 SHALL have the port `flush`, output, 1 bit: squashes the wrong-path fetch.

Function
REQ-015 SHALL decode the following; any other instruction is a non-branch:
- B: instr[31:26]=000101.
- CBZ: instr[31:24]=10110100.
- B.cond: instr[31:24]=01010100.
REQ-016 SHALL compute the B target as pc + (sext(instr[25:0])<<2), with 64-bit wrap-around and no overflow detection.
REQ-017 SHALL compute the CBZ and B.cond target as pc + (sext(instr[23:5])<<2), with 64-bit wrap-around.
REQ-018 SHALL evaluate B.cond conditions as follows; codes 0110-1001 and 1111 are not taken:
- EQ(0000): Z.
- NE(0001): !Z.
- GE(1010): N==V.
- LT(1011): N!=V.
- GT(1100): !Z & N==V.
- LE(1101): Z | N!=V.
- AL(1110): taken.
- 0010-0101 (carry/sign codes): per the standard ARMv8 definitions.
REQ-019 SHALL treat CBZ as taken iff rt_val==0.
REQ-020 SHALL implement the states IDLE, WAIT and REDIRECT.
REQ-021 SHALL, in IDLE with valid, behave as follows:
- B: latch target; go to REDIRECT.
- CBZ/B.cond with operand ready: evaluate; if taken, latch target and go to REDIRECT; if not taken, stay in IDLE.
- CBZ/B.cond with operand not ready: latch instr, pc and target; go to WAIT.
- Non-branch: stay in IDLE.
REQ-022 SHALL, in WAIT, ignore valid and instr and evaluate the latched branch on the first cycle its operand is ready: taken goes to REDIRECT, not taken goes to IDLE.
REQ-023 SHALL, in REDIRECT, drive pc_src=1 and flush=1; it SHALL leave REDIRECT for IDLE only on a cycle where stall_req=0.
REQ-024 SHALL drive pc_en = !stall_req & !(state==WAIT) & !(IDLE & valid & conditional branch & operand not ready).
REQ-025 SHALL drive pc_src=0 and flush=0 outside REDIRECT.
REQ-026 SHALL drive `target` from a register that holds its value until the next latch.
REQ-027 SHALL produce a redirect one cycle after the branch is accepted, or one cycle after its operand becomes ready.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-WAIT or mid-REDIRECT, immediately force state=IDLE, target=0 and the latched instr/pc=0.
REQ-029 SHALL hold pc_src=0, flush=0 and pc_en=0 while reset=1.
REQ-030 SHALL start IDLE decoding on the first rising clock edge after reset deasserts.

Structure
REQ-031 SHALL place the opcode constants, condition codes and state encoding in a shared package, branch_pkg.
REQ-032 SHALL implement the condition evaluation as one combinational sub-module, cond_check (inputs cond[3:0] and flags, output taken).

Verification
REQ-033 SHALL cover: pc=0x100, instr=B imm26=4 -> next cycle target=0x110, pc_src=1, flush=1, then IDLE.
REQ-034 SHALL cover: pc=0x40, B imm26=0x3FFFFFF (-1) -> target=0x3C; pc=0, B imm26=-1 -> target=0xFFFFFFFFFFFFFFFC (wrap).
REQ-035 SHALL cover: B.EQ imm19=2 at pc=0x200 with flags_rdy=0 for 3 cycles -> pc_en=0 for those 3 cycles; then flags_rdy=1, Z=1 -> target=0x208, REDIRECT; with Z=0 instead -> IDLE, pc_src never 1.
REQ-036 SHALL cover: CBZ with rt_rdy=1 and rt_val=5 -> no redirect and pc_en=1 throughout; rt_val=0 -> redirect.
REQ-037 SHALL cover: stall_req=1 held for 2 cycles during REDIRECT -> pc_src/flush held at 1 with pc_en=0; a single pc_en pulse follows when stall_req drops.
REQ-038 SHALL cover: reset asserted asynchronously in WAIT -> outputs go to 0 before the next edge; the first valid B after release redirects normally.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared decode constants, state encoding and target arithmetic for the branch resolver.
package branch_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [5:0] OP_B     = 6'b000101;
    localparam logic [7:0] OP_CBZ   = 8'b10110100;
    localparam logic [7:0] OP_BCOND = 8'b01010100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_B    = 2'd1,
        BR_CBZ  = 2'd2,
        BR_COND = 2'd3
    } br_kind_t;

    // Branch held while its operand is outstanding
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } br_latch_t;

    function automatic br_kind_t decode_kind(input logic [7:0] op);
        br_kind_t k;
        k = BR_NONE;
        if (op[7:2] == OP_B)        k = BR_B;
        else if (op == OP_CBZ)      k = BR_CBZ;
        else if (op == OP_BCOND)    k = BR_COND;
        return k;
    endfunction

    // Word-scaled, sign-extended displacement added with 64-bit wrap
    function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc,
                                                      input logic [ILEN-1:0] instr);
        logic [XLEN-1:0] off;
        if (decode_kind(instr[31:24]) == BR_B)
            off = {{(XLEN-28){instr[25]}}, instr[25:0], 2'b00};
        else
            off = {{(XLEN-21){instr[23]}}, instr[23:5], 2'b00};
        return pc + off;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Evaluates a B.cond condition code against the {N,Z,V,C} flags.
module cond_check
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, z, v, c;

    assign n = flags[3];
    assign z = flags[2];
    assign v = flags[1];
    assign c = flags[0];

    // Overflow and unsigned-compare codes resolve as never taken here
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z && (n == v);
            COND_LE: taken = z || (n != v);
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves B / CBZ / B.cond in fetch, holding the PC while operands are outstanding.
module branch_resolver
    import branch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [ILEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic            valid,
    input  logic [3:0]      flags,
    input  logic            flags_rdy,
    input  logic [XLEN-1:0] rt_val,
    input  logic            rt_rdy,
    input  logic            stall_req,
    output logic [XLEN-1:0] target,
    output logic            pc_src,
    output logic            pc_en,
    output logic            flush
);

    state_t          state, state_nx;
    br_latch_t       lat;
    logic            tgt_load, lat_load;

    logic [ILEN-1:0] sel_instr;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] sel_target;
    br_kind_t        sel_kind;
    logic            cond_taken;
    logic            opnd_rdy;
    logic            br_taken;

    // In WAIT the latched branch is evaluated; otherwise the incoming one
    assign sel_instr  = (state == WAIT) ? lat.instr : instr;
    assign sel_pc     = (state == WAIT) ? lat.pc    : pc;
    assign sel_kind   = decode_kind(sel_instr[31:24]);
    assign sel_target = branch_target(sel_pc, sel_instr);

    cond_check u_cond_check (
        .cond  (sel_instr[3:0]),
        .flags (flags),
        .taken (cond_taken)
    );

    always_comb begin
        opnd_rdy = 1'b1;
        br_taken = 1'b0;
        case (sel_kind)
            BR_B:    br_taken = 1'b1;
            BR_CBZ: begin
                opnd_rdy = rt_rdy;
                br_taken = (rt_val == '0);
            end
            BR_COND: begin
                opnd_rdy = flags_rdy;
                br_taken = cond_taken;
            end
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tgt_load = 1'b0;
        lat_load = 1'b0;
        pc_src   = 1'b0;
        flush    = 1'b0;
        pc_en    = !stall_req;
        case (state)
            IDLE: begin
                if (valid && sel_kind != BR_NONE) begin
                    if (!opnd_rdy) begin
                        tgt_load = 1'b1;
                        lat_load = 1'b1;
                        pc_en    = 1'b0;
                        state_nx = WAIT;
                    end else if (br_taken) begin
                        tgt_load = 1'b1;
                        state_nx = REDIRECT;
                    end
                end
            end
            WAIT: begin
                pc_en = 1'b0;
                if (opnd_rdy) begin
                    if (br_taken) begin
                        tgt_load = 1'b1;
                        state_nx = REDIRECT;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            REDIRECT: begin
                pc_src = 1'b1;
                flush  = 1'b1;
                if (!stall_req) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (reset) pc_en = 1'b0;
    end

    // Redirect address and pending-branch capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target <= '0;
            lat    <= '0;
        end else begin
            if (tgt_load) target <= sel_target;
            if (lat_load) begin
                lat.instr <= instr;
                lat.pc    <= pc;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a cycle-level reference model and per-cycle compare.
module tb_branch_resolver;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        valid;
    logic [3:0]  flags;
    logic        flags_rdy;
    logic [63:0] rt_val;
    logic        rt_rdy;
    logic        stall_req;
    logic [63:0] target;
    logic        pc_src;
    logic        pc_en;
    logic        flush;

    int checks = 0;
    int errors = 0;

    branch_resolver dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .pc        (pc),
        .valid     (valid),
        .flags     (flags),
        .flags_rdy (flags_rdy),
        .rt_val    (rt_val),
        .rt_rdy    (rt_rdy),
        .stall_req (stall_req),
        .target    (target),
        .pc_src    (pc_src),
        .pc_en     (pc_en),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_b(input logic [31:0] i);    return i[31:26] == 6'b000101; endfunction
    function automatic bit is_cbz(input logic [31:0] i);  return i[31:24] == 8'hB4;     endfunction
    function automatic bit is_bc(input logic [31:0] i);   return i[31:24] == 8'h54;     endfunction

    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, v, cy;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] ref_target(input logic [63:0] p, input logic [31:0] i);
        longint off;
        if (is_b(i)) off = longint'($signed(i[25:0]));
        else         off = longint'($signed(i[23:5]));
        return p + 64'(off * 4);
    endfunction

    function automatic bit ref_ready(input logic [31:0] i);
        return is_cbz(i) ? rt_rdy : flags_rdy;
    endfunction

    function automatic bit ref_taken(input logic [31:0] i);
        if (is_b(i))   return 1'b1;
        if (is_cbz(i)) return rt_val == 64'd0;
        if (is_bc(i))  return ref_cond(i[3:0], flags);
        return 1'b0;
    endfunction

    bit          m_redir = 0;
    bit          m_wait  = 0;
    logic [31:0] m_instr = '0;
    logic [63:0] m_pc    = '0;
    logic [63:0] m_target = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_redir = 0; m_wait = 0; m_instr = '0; m_pc = '0; m_target = '0;
        end else if (m_redir) begin
            if (!stall_req) m_redir = 0;
        end else if (m_wait) begin
            if (ref_ready(m_instr)) begin
                m_wait = 0;
                if (ref_taken(m_instr)) begin
                    m_redir  = 1;
                    m_target = ref_target(m_pc, m_instr);
                end
            end
        end else if (valid) begin
            if (is_b(instr)) begin
                m_redir = 1; m_target = ref_target(pc, instr);
            end else if (is_cbz(instr) || is_bc(instr)) begin
                if (!ref_ready(instr)) begin
                    m_wait = 1; m_instr = instr; m_pc = pc; m_target = ref_target(pc, instr);
                end else if (ref_taken(instr)) begin
                    m_redir = 1; m_target = ref_target(pc, instr);
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit hold;
        hold = !m_redir && !m_wait && valid && (is_cbz(instr) || is_bc(instr)) && !ref_ready(instr);
        chk("model_pc_src", 64'(pc_src), 64'(!reset && m_redir));
        chk("model_flush",  64'(flush),  64'(!reset && m_redir));
        chk("model_pc_en",  64'(pc_en),  64'(!reset && !stall_req && !m_wait && !hold));
        chk("model_target", target, m_target);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic quiet();
        valid = 0; instr = 32'h0; pc = '0; flags = 4'h0; flags_rdy = 1;
        rt_val = 64'd1; rt_rdy = 1; stall_req = 0;
    endtask

    logic [3:0] ct_cond  [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11, 4'd12, 4'd13, 4'd15};
    logic [3:0] ct_flags [12] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0010,
                                  4'b1010, 4'b1000, 4'b0100, 4'b0010, 4'b1111};
    bit         ct_exp   [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        quiet();
        reset = 1;
        look();
        chk("rst_pc_src", 64'(pc_src), 64'd0);
        chk("rst_flush",  64'(flush),  64'd0);
        chk("rst_pc_en",  64'(pc_en),  64'd0);
        chk("rst_target", target, 64'd0);
        @(negedge clk); #1 reset = 0;
        tick();

        // B forward
        valid = 1; instr = 32'h14000004; pc = 64'h100;
        look(); chk("b_accept_pc_en", 64'(pc_en), 64'd1);
        tick(); quiet();
        look();
        chk("b_target", target, 64'h110);
        chk("b_pc_src", 64'(pc_src), 64'd1);
        chk("b_flush",  64'(flush),  64'd1);
        tick(); look(); chk("b_back_idle", 64'(pc_src), 64'd0);

        // B backward and wrap
        tick(); valid = 1; instr = 32'h17FFFFFF; pc = 64'h40;
        tick(); quiet(); look(); chk("b_neg_target", target, 64'h3C);
        tick(); valid = 1; instr = 32'h17FFFFFF; pc = 64'h0;
        tick(); quiet(); look(); chk("b_wrap_target", target, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();

        // Non-branch passes through
        valid = 1; instr = 32'h8B020020; pc = 64'h500;
        look(); chk("nonbr_pc_en", 64'(pc_en), 64'd1);
        tick(); quiet(); look(); chk("nonbr_no_redir", 64'(pc_src), 64'd0);
        tick();

        // B.EQ waiting on flags, then taken
        valid = 1; instr = 32'h54000040; pc = 64'h200; flags_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            look(); chk("beq_wait_pc_en", 64'(pc_en), 64'd0);
            tick();
            valid = 1; instr = 32'h14000010; pc = 64'h900;
        end
        valid = 0; flags_rdy = 1; flags = 4'b0100;
        look(); chk("beq_rdy_pc_en", 64'(pc_en), 64'd0);
        tick(); quiet();
        look();
        chk("beq_target", target, 64'h208);
        chk("beq_pc_src", 64'(pc_src), 64'd1);
        tick();

        // B.EQ waiting on flags, then not taken
        valid = 1; instr = 32'h54000040; pc = 64'h200; flags_rdy = 0;
        tick(); valid = 0;
        look(); chk("beq_nt_wait", 64'(pc_src), 64'd0);
        tick(); flags_rdy = 1; flags = 4'b0000;
        look(); chk("beq_nt_eval", 64'(pc_src), 64'd0);
        tick(); look(); chk("beq_nt_idle", 64'(pc_src), 64'd0);
        chk("beq_nt_pc_en", 64'(pc_en), 64'd1);
        tick();

        // CBZ immediate
        valid = 1; instr = 32'hB4000060; pc = 64'h1000; rt_rdy = 1; rt_val = 64'd5;
        look(); chk("cbz_nz_pc_en", 64'(pc_en), 64'd1);
        tick(); quiet(); look(); chk("cbz_nz_no_redir", 64'(pc_src), 64'd0);
        chk("cbz_nz_pc_en2", 64'(pc_en), 64'd1);
        tick();
        valid = 1; instr = 32'hB4000060; pc = 64'h1000; rt_val = 64'd0;
        tick(); quiet(); look();
        chk("cbz_z_pc_src", 64'(pc_src), 64'd1);
        chk("cbz_z_target", target, 64'h100C);
        tick();

        // Condition-code sweep
        for (int k = 0; k < 12; k++) begin
            valid = 1; instr = {8'h54, 19'd4, 1'b0, ct_cond[k]}; pc = 64'h800;
            flags = ct_flags[k]; flags_rdy = 1;
            tick(); quiet(); look();
            chk($sformatf("cond_%0d_taken", ct_cond[k]), 64'(pc_src), 64'(ct_exp[k]));
            tick();
        end

        // Stall during REDIRECT
        valid = 1; instr = 32'h14000001; pc = 64'h300;
        tick(); quiet(); stall_req = 1;
        for (int i = 0; i < 2; i++) begin
            look();
            chk("stall_pc_src", 64'(pc_src), 64'd1);
            chk("stall_flush",  64'(flush),  64'd1);
            chk("stall_pc_en",  64'(pc_en),  64'd0);
            tick();
        end
        stall_req = 0;
        look();
        chk("unstall_pc_en",  64'(pc_en),  64'd1);
        chk("unstall_pc_src", 64'(pc_src), 64'd1);
        chk("unstall_target", target, 64'h304);
        tick(); look(); chk("unstall_idle", 64'(pc_src), 64'd0);
        tick();

        // Asynchronous reset in WAIT
        valid = 1; instr = 32'h54000040; pc = 64'h200; flags_rdy = 0;
        tick(); valid = 0;
        #2 reset = 1;
        #1;
        chk("arst_pc_src", 64'(pc_src), 64'd0);
        chk("arst_flush",  64'(flush),  64'd0);
        chk("arst_pc_en",  64'(pc_en),  64'd0);
        chk("arst_target", target, 64'd0);
        tick();
        @(negedge clk); #1 reset = 0; quiet();
        tick();
        valid = 1; instr = 32'h14000004; pc = 64'h100;
        tick(); quiet(); look();
        chk("post_rst_pc_src", 64'(pc_src), 64'd1);
        chk("post_rst_target", target, 64'h110);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
